// File: rtl/lcd_frame_packer.sv
// lcd_frame_packer: double-buffers 4x4 pixel frames from the LCD controller and
// streams each frame out as four packed rows of four pixels, with a per-frame sum.
module lcd_frame_packer #(
   parameter int PIX_W     = 8,
   parameter int FRAME_PIX = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PIX_W-1:0]   pix_in,
   input  logic               pix_valid,
   input  logic               clr_ovf,
   output logic [4*PIX_W-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [1:0]         out_row,
   output logic               out_last,
   output logic [11:0]        frame_sum,
   output logic               sum_valid,
   output logic               overflow
);

   localparam int          PTR_W    = $clog2(FRAME_PIX);
   localparam int          SUM_W    = 12;
   localparam int          ROWS     = FRAME_PIX / 4;
   localparam logic [1:0]  LAST_ROW = 2'(ROWS - 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_PIX - 1);

   typedef enum logic {IDLE, SEND} state_t;

   logic [PIX_W-1:0] mem [2][FRAME_PIX];
   logic [1:0]       full;
   logic             wr_bank;
   logic [PTR_W-1:0] wr_ptr;
   logic             rd_bank;
   state_t           state;
   logic [SUM_W-1:0] acc;

   logic             accept;
   logic             drop;
   logic             wr_done;
   logic             rd_done;
   logic [1:0]       next_row;
   logic [SUM_W-1:0] pix_ext;

   assign accept   = pix_valid && !full[wr_bank];
   assign drop     = pix_valid && full[wr_bank];
   assign wr_done  = accept && (wr_ptr == LAST_PTR);
   assign rd_done  = (state == SEND) && out_ready && (out_row == LAST_ROW);
   assign next_row = out_row + 2'd1;
   assign pix_ext  = SUM_W'(pix_in);

   // Row r of a bank, leftmost (lowest-addressed) pixel in the low bits.
   function automatic logic [4*PIX_W-1:0] pack_row(input logic bank, input logic [1:0] r);
      logic [4*PIX_W-1:0] row_bits;
      row_bits = '0;
      for (int k = 0; k < 4; k++) begin
         row_bits[k*PIX_W +: PIX_W] = mem[bank][PTR_W'(4 * int'(r) + k)];
      end
      return row_bits;
   endfunction

   // NOTE: pixel storage has no reset; the full flags alone decide what is valid,
   // so stale contents after reset are never read.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_bank][wr_ptr] <= pix_in;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every block
   // sees the pre-edge values of the others regardless of evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_bank   <= 1'b0;
         wr_ptr    <= '0;
         acc       <= '0;
         frame_sum <= '0;
         sum_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         sum_valid <= 1'b0;
         if (accept) begin
            acc <= (wr_ptr == '0) ? pix_ext : acc + pix_ext;
            if (wr_done) begin
               wr_ptr    <= '0;
               wr_bank   <= ~wr_bank;
               frame_sum <= ((wr_ptr == '0) ? '0 : acc) + pix_ext;
               sum_valid <= 1'b1;
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
            end
         end
         // A drop wins over a simultaneous clear so no lost pixel goes unreported.
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

   // Writer sets and reader clears never target the same bank in one cycle:
   // the writer can only be on the read bank when that bank is already full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full <= 2'b00;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (wr_done && (wr_bank == 1'(b))) begin
               full[b] <= 1'b1;
            end else if (rd_done && (rd_bank == 1'(b))) begin
               full[b] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rd_bank   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (full[rd_bank]) begin
                  state     <= SEND;
                  out_valid <= 1'b1;
                  out_data  <= pack_row(rd_bank, 2'd0);
                  out_row   <= 2'd0;
                  out_last  <= (LAST_ROW == 2'd0);
               end
            end
            SEND: begin
               if (out_ready) begin
                  if (out_row != LAST_ROW) begin
                     out_row  <= next_row;
                     out_data <= pack_row(rd_bank, next_row);
                     out_last <= (next_row == LAST_ROW);
                  end else begin
                     rd_bank  <= ~rd_bank;
                     out_row  <= 2'd0;
                     out_last <= (LAST_ROW == 2'd0);
                     // Other bank already complete: continue without an idle cycle.
                     if (full[~rd_bank]) begin
                        out_data <= pack_row(~rd_bank, 2'd0);
                     end else begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_frame_packer.sv
// Self-checking bench for lcd_frame_packer: table-driven frame sums, directed
// corner sequences and randomized traffic against a frame-level reference model.
module tb_lcd_frame_packer;

   localparam int PIX_W     = 8;
   localparam int FRAME_PIX = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic [PIX_W-1:0]   pix_in;
   logic               pix_valid;
   logic               clr_ovf;
   logic [4*PIX_W-1:0] out_data;
   logic               out_valid;
   logic               out_ready;
   logic [1:0]         out_row;
   logic               out_last;
   logic [11:0]        frame_sum;
   logic               sum_valid;
   logic               overflow;

   always #5 clk = ~clk;

   lcd_frame_packer #(.PIX_W(PIX_W), .FRAME_PIX(FRAME_PIX)) dut (
      .clk       (clk),
      .reset     (reset),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .clr_ovf   (clr_ovf),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row),
      .out_last  (out_last),
      .frame_sum (frame_sum),
      .sum_valid (sum_valid),
      .overflow  (overflow)
   );

   typedef struct {
      logic [4*PIX_W-1:0] data;
      int                 row;
   } row_t;

   typedef struct {
      int start;
      int step;
      int exp_sum;
   } frame_vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: buffered complete frames, the frame being collected,
   // the expected row stream, and the flags the outputs should show.
   row_t             exp_q[$];
   logic [PIX_W-1:0] cur[$];
   int               pending;
   logic             m_ovf;
   logic             m_pulse;
   int               m_sum;
   int               hs_count;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      cur.delete();
      pending = 0;
      m_ovf   = 1'b0;
      m_pulse = 1'b0;
      m_sum   = 0;
   endtask

   // One clock cycle: drive inputs at a falling edge, check what the DUT shows
   // during this cycle, advance the model over the coming rising edge.
   task automatic cycle(input logic pv, input logic [PIX_W-1:0] px, input logic rdy, input logic clr);
      logic acc_pix;
      logic hs_last;
      int   s;
      pix_valid = pv;
      pix_in    = px;
      out_ready = rdy;
      clr_ovf   = clr;
      check("overflow", overflow, m_ovf);
      check("sum_valid", sum_valid, m_pulse);
      check("frame_sum", frame_sum, m_sum);
      hs_last = 1'b0;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_out_valid: got out_valid=1, expected 0 (no row pending)");
         end else begin
            check("out_data", out_data, exp_q[0].data);
            check("out_row", out_row, exp_q[0].row);
            check("out_last", out_last, exp_q[0].row == 3);
            if (rdy) begin
               hs_count++;
               hs_last = (exp_q[0].row == 3);
               void'(exp_q.pop_front());
            end
         end
      end
      // Up to two complete frames can be held; a third is dropped pixel by pixel.
      acc_pix = pv && (pending < 2);
      m_ovf   = (pv && !acc_pix) || (m_ovf && !clr);
      m_pulse = 1'b0;
      if (acc_pix) begin
         cur.push_back(px);
         if (cur.size() == FRAME_PIX) begin
            s = 0;
            foreach (cur[i]) s += int'(cur[i]);
            m_sum   = s;
            m_pulse = 1'b1;
            for (int r = 0; r < 4; r++) begin
               row_t e;
               e.data = {cur[4*r+3], cur[4*r+2], cur[4*r+1], cur[4*r]};
               e.row  = r;
               exp_q.push_back(e);
            end
            cur.delete();
            pending++;
         end
      end
      if (hs_last) pending--;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      pix_valid = 1'b0;
      pix_in    = '0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_row", out_row, 0);
      check("rst_out_last", out_last, 0);
      check("rst_frame_sum", frame_sum, 0);
      check("rst_sum_valid", sum_valid, 0);
      check("rst_overflow", overflow, 0);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      @(negedge clk);
   endtask

   // mode 0: always ready, 1: ready toggles every cycle, 2: random ready.
   task automatic drain(input int mode);
      int   guard;
      logic rdy;
      guard = 0;
      while ((exp_q.size() != 0 || pending != 0) && guard < 400) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = guard[0];
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         cycle(1'b0, '0, rdy, 1'b0);
         guard++;
      end
      if (exp_q.size() != 0 || pending != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d rows still pending, expected 0", exp_q.size());
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
   endtask

   frame_vec_t tbl[5];

   initial begin
      tbl[0] = '{start: 1,   step: 1, exp_sum: 136};
      tbl[1] = '{start: 255, step: 0, exp_sum: 4080};
      tbl[2] = '{start: 0,   step: 0, exp_sum: 0};
      tbl[3] = '{start: 10,  step: 5, exp_sum: 760};
      tbl[4] = '{start: 240, step: 1, exp_sum: 3960};

      model_clear();
      do_reset();

      // Table-driven frames, downstream always ready.
      foreach (tbl[t]) begin
         for (int i = 0; i < FRAME_PIX; i++) begin
            cycle(1'b1, PIX_W'(tbl[t].start + tbl[t].step * i), 1'b1, 1'b0);
         end
         check("tbl_frame_sum", frame_sum, tbl[t].exp_sum);
         check("tbl_sum_valid", sum_valid, 1);
      end
      drain(0);

      // Three frames with the panel stalled: two buffered, third dropped,
      // with clr_ovf colliding with drops along the way.
      for (int i = 0; i < 3 * FRAME_PIX; i++) begin
         cycle(1'b1, PIX_W'(i + 1), 1'b0, (i >= 37 && i <= 39));
      end
      cycle(1'b0, '0, 1'b0, 1'b0);
      check("ovf_after_drops", overflow, 1);
      hs_count = 0;
      for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      check("b2b_handshakes", hs_count, 8);
      cycle(1'b0, '0, 1'b1, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("ovf_cleared", overflow, 0);
      drain(0);

      // Ready toggling every cycle while a frame streams out.
      for (int i = 0; i < FRAME_PIX; i++) cycle(1'b1, PIX_W'(100 + 3 * i), i[0], 1'b0);
      drain(1);

      // Random gaps over two frames, random ready.
      begin
         int sent;
         sent = 0;
         while (sent < 2 * FRAME_PIX) begin
            logic pv;
            pv = ($urandom_range(0, 99) < 40);
            cycle(pv, PIX_W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            if (pv) sent++;
         end
      end
      drain(2);

      // Reset mid-frame discards the partial frame.
      for (int i = 0; i < 7; i++) cycle(1'b1, PIX_W'(200 + i), 1'b1, 1'b0);
      do_reset();
      for (int i = 0; i < FRAME_PIX; i++) cycle(1'b1, PIX_W'(50 + i), 1'b1, 1'b0);
      drain(0);
      check("ovf_after_reset", overflow, 0);

      // Reset while a frame is being sent.
      for (int i = 0; i < FRAME_PIX; i++) cycle(1'b1, PIX_W'(i * 7), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      do_reset();
      drain(0);

      // Long randomized soak with sticky overflow and clears.
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom_range(0, 99) < 70), PIX_W'($urandom),
               ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5));
      end
      drain(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
